// File: rtl/wb_pkg.sv
// Shared Wishbone interconnect types and helpers.
// Provides the arbiter state enum, default widths and index-width helper.
package wb_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker.
// Ports: req (requests), last (previous winner) -> grant (winner), any_req.
module wb_rr_picker
    import wb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          any_req
);

    int j;

    // Search starts one past the previous winner and wraps, so the
    // previous winner is considered last.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        j       = 0;
        for (int i = 1; i <= N; i++) begin
            j = int'(last) + i;
            if (j >= N) j = j - N;
            if (!any_req && req[j]) begin
                any_req = 1'b1;
                grant   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// N-master Wishbone classic arbiter with round-robin grant and watchdog.
// Ports: m_* master side (sliced per master), s_* slave side, grant_idx/busy status.
module wb_master_arbiter
    import wb_pkg::*;
#(
    parameter  int N_MASTERS = 2,
    parameter  int ADDR_W    = DEF_ADDR_W,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int TIMEOUT   = 256,
    localparam int IW        = idx_w(N_MASTERS),
    localparam int SW        = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*ADDR_W-1:0] m_adr,
    input  logic [N_MASTERS*DATA_W-1:0] m_dat_mosi,
    input  logic [N_MASTERS*SW-1:0]     m_sel,
    input  logic [N_MASTERS-1:0]        m_we,
    input  logic [N_MASTERS-1:0]        m_stb,
    input  logic [N_MASTERS-1:0]        m_cyc,
    output logic [DATA_W-1:0]           m_dat_miso,
    output logic [N_MASTERS-1:0]        m_ack,
    output logic [N_MASTERS-1:0]        m_err,
    output logic [ADDR_W-1:0]           s_adr,
    output logic [DATA_W-1:0]           s_dat_mosi,
    output logic [SW-1:0]               s_sel,
    output logic                        s_we,
    output logic                        s_stb,
    output logic                        s_cyc,
    input  logic [DATA_W-1:0]           s_dat_miso,
    input  logic                        s_ack,
    input  logic                        s_err,
    output logic [IW-1:0]               grant_idx,
    output logic                        busy
);

    arb_state_t    state;
    logic [IW-1:0] last;
    logic [IW-1:0] pick;
    logic          any_req;
    logic          err_pend;

    wb_rr_picker #(.N(N_MASTERS)) u_picker (
        .req     (m_cyc),
        .last    (last),
        .grant   (pick),
        .any_req (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            grant_idx <= '0;
            last      <= IW'(N_MASTERS - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= BUSY;
                        busy      <= 1'b1;
                        grant_idx <= pick;
                        last      <= pick;
                    end
                end
                BUSY: begin
                    // Tenure lasts for the whole of the owner's cyc.
                    if (!m_cyc[grant_idx]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    if (TIMEOUT > 0) begin : g_wd
        localparam int CW = $clog2(TIMEOUT + 1);
        logic [CW-1:0] count;

        // err_pend is a one-cycle pulse; it masks s_stb, which in turn
        // clears the count, so the watchdog restarts cleanly.
        always_ff @(posedge clk) begin
            if (rst) begin
                count    <= '0;
                err_pend <= 1'b0;
            end else begin
                err_pend <= 1'b0;
                if (!s_stb || s_ack || s_err) begin
                    count <= '0;
                end else if (count == CW'(TIMEOUT - 1)) begin
                    count    <= '0;
                    err_pend <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
            end
        end
    end else begin : g_no_wd
        assign err_pend = 1'b0;
    end

    assign s_adr      = m_adr[grant_idx*ADDR_W +: ADDR_W];
    assign s_dat_mosi = m_dat_mosi[grant_idx*DATA_W +: DATA_W];
    assign s_sel      = m_sel[grant_idx*SW +: SW];
    assign s_we       = m_we[grant_idx];
    assign s_cyc      = busy & m_cyc[grant_idx];
    assign s_stb      = busy & m_stb[grant_idx] & ~err_pend;
    assign m_dat_miso = s_dat_miso;

    // Slave err beats a same-cycle ack.
    always_comb begin
        m_ack = '0;
        m_err = '0;
        if (busy) begin
            m_ack[grant_idx] = s_ack & ~s_err & ~err_pend;
            m_err[grant_idx] = s_err | err_pend;
        end
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter (2 masters, TIMEOUT=8).
// Responses are predicted into a scoreboard and matched by a monitor.
module tb_wb_master_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_mosi;
    logic [N*SW-1:0] m_sel;
    logic [N-1:0]    m_we;
    logic [N-1:0]    m_stb;
    logic [N-1:0]    m_cyc;
    logic [DW-1:0]   m_dat_miso;
    logic [N-1:0]    m_ack;
    logic [N-1:0]    m_err;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_mosi;
    logic [SW-1:0]   s_sel;
    logic            s_we;
    logic            s_stb;
    logic            s_cyc;
    logic [DW-1:0]   s_dat_miso;
    logic            s_ack;
    logic            s_err;
    logic [0:0]      grant_idx;
    logic            busy;

    wb_master_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_adr      (m_adr),
        .m_dat_mosi (m_dat_mosi),
        .m_sel      (m_sel),
        .m_we       (m_we),
        .m_stb      (m_stb),
        .m_cyc      (m_cyc),
        .m_dat_miso (m_dat_miso),
        .m_ack      (m_ack),
        .m_err      (m_err),
        .s_adr      (s_adr),
        .s_dat_mosi (s_dat_mosi),
        .s_sel      (s_sel),
        .s_we       (s_we),
        .s_stb      (s_stb),
        .s_cyc      (s_cyc),
        .s_dat_miso (s_dat_miso),
        .s_ack      (s_ack),
        .s_err      (s_err),
        .grant_idx  (grant_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic [31:0] d;
        bit          err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input int m, input logic [31:0] adr,
                           input logic we);
        m_adr[m*AW +: AW]      = adr;
        m_dat_mosi[m*DW +: DW] = adr ^ 32'h5A5A_0000;
        m_sel[m*SW +: SW]      = '1;
        m_we[m]                = we;
        m_cyc[m]               = 1'b1;
        m_stb[m]               = 1'b1;
    endtask

    task automatic drop(input int m);
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    task automatic wait_busy(input string tag, output int idle);
        idle = 0;
        while (!busy && idle < 20) begin
            idle++;
            tick();
        end
        check(tag, 64'(busy), 64'd1);
    endtask

    // One single-beat tenure for master m, acked in the grant cycle.
    task automatic serve(input int m, input logic [31:0] d,
                         input bit again, input bit chk_idle);
        int idle;
        wait_busy("serve_busy", idle);
        check("serve_grant", 64'(grant_idx), 64'(m));
        if (chk_idle) check("idle_gap", 64'(idle), 64'd1);
        s_ack      = 1'b1;
        s_dat_miso = d;
        sb.push_back('{m, d, 1'b0});
        tick();
        s_ack = 1'b0;
        drop(m);
        tick();
        if (again) request(m, 32'h2000 + 32'(m), 1'b1);
    endtask

    // Monitor: every delivered response must match the oldest prediction.
    always @(negedge clk) begin
        if (m_ack != '0 || m_err != '0) begin
            check("resp_onehot", 64'($countones(m_ack | m_err)), 64'd1);
            if (sb.size() == 0) begin
                check("resp_unexpected", 64'(m_ack | m_err), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_master", 64'(m_ack[mon_e.m] | m_err[mon_e.m]),
                      64'd1);
                check("resp_kind", 64'(m_err[mon_e.m]), 64'(mon_e.err));
                if (!mon_e.err)
                    check("resp_data", 64'(m_dat_miso), 64'(mon_e.d));
            end
        end
    end

    initial begin
        int idle;
        rst        = 1'b1;
        m_adr      = '0;
        m_dat_mosi = '0;
        m_sel      = '0;
        m_we       = '0;
        m_stb      = '0;
        m_cyc      = '0;
        s_dat_miso = '0;
        s_ack      = 1'b0;
        s_err      = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant_idx), 64'd0);
        check("rst_scyc", 64'(s_cyc), 64'd0);
        check("rst_ack_err", 64'({m_ack, m_err}), 64'd0);

        // Single request from master 1.
        rst = 1'b0;
        request(1, 32'h1000, 1'b0);
        tick();
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_grant", 64'(grant_idx), 64'd1);
        check("t1_adr", 64'(s_adr), 64'h1000);
        check("t1_scyc", 64'({s_cyc, s_stb, s_we}), 64'b110);
        tick();
        check("t1_noack", 64'(m_ack), 64'd0);
        tick();
        s_ack      = 1'b1;
        s_dat_miso = 32'hDEAD_BEEF;
        sb.push_back('{1, 32'hDEAD_BEEF, 1'b0});
        #1;
        check("t1_ack", 64'(m_ack), 64'b10);
        check("t1_data", 64'(m_dat_miso), 64'hDEAD_BEEF);
        tick();
        s_ack = 1'b0;
        drop(1);
        tick();

        // Simultaneous requests: order 0, 1, 0 with one idle cycle between.
        request(0, 32'h2000, 1'b1);
        request(1, 32'h2001, 1'b1);
        serve(0, 32'h1111_0000, 1'b1, 1'b0);
        serve(1, 32'h2222_0001, 1'b0, 1'b1);
        serve(0, 32'h3333_0000, 1'b0, 1'b1);

        // Locked burst: master 1 waits for master 0 to drop cyc.
        request(0, 32'h3000, 1'b0);
        wait_busy("burst_busy", idle);
        check("burst_grant", 64'(grant_idx), 64'd0);
        request(1, 32'h3100, 1'b0);
        for (int b = 0; b < 4; b++) begin
            s_ack      = 1'b1;
            s_dat_miso = 32'hB000_0000 + 32'(b);
            sb.push_back('{0, 32'hB000_0000 + 32'(b), 1'b0});
            #1;
            check("burst_ack1_low", 64'(m_ack[1]), 64'd0);
            tick();
            s_ack = 1'b0;
            check("burst_hold", 64'({busy, grant_idx}), 64'b10);
            check("burst_ack1_idle", 64'(m_ack[1]), 64'd0);
            tick();
        end
        drop(0);
        tick();
        serve(1, 32'hC0DE_0001, 1'b0, 1'b1);

        // Watchdog: forced err in cycle TIMEOUT, then a normal transfer.
        request(1, 32'h4000, 1'b0);
        wait_busy("wd_busy", idle);
        check("wd_grant", 64'(grant_idx), 64'd1);
        for (int k = 0; k < TO; k++) begin
            check("wd_no_err", 64'(m_err), 64'd0);
            tick();
        end
        sb.push_back('{1, 32'h0, 1'b1});
        s_ack = 1'b1;
        #1;
        check("wd_err", 64'(m_err), 64'b10);
        check("wd_stb_low", 64'(s_stb), 64'd0);
        check("wd_late_ack", 64'(m_ack), 64'd0);
        tick();
        s_ack = 1'b0;
        check("wd_clear", 64'({m_err, s_stb}), 64'b001);
        tick();
        check("wd_2nd_c1", 64'(m_err), 64'd0);
        tick();
        s_ack      = 1'b1;
        s_dat_miso = 32'h600D_0002;
        sb.push_back('{1, 32'h600D_0002, 1'b0});
        #1;
        check("wd_2nd_ack", 64'({m_ack, m_err}), 64'b1000);
        tick();
        s_ack = 1'b0;
        drop(1);
        tick();

        // Same-cycle ack and err: err wins.
        request(0, 32'h5000, 1'b1);
        wait_busy("both_busy", idle);
        check("both_grant", 64'(grant_idx), 64'd0);
        s_ack = 1'b1;
        s_err = 1'b1;
        sb.push_back('{0, 32'h0, 1'b1});
        #1;
        check("both_err", 64'(m_err), 64'b01);
        check("both_ack", 64'(m_ack), 64'd0);
        tick();
        s_ack = 1'b0;
        s_err = 1'b0;
        drop(0);
        tick();

        // Reset during a tenure of master 1.
        request(1, 32'h6000, 1'b0);
        wait_busy("rst_mid_busy", idle);
        check("rst_mid_grant", 64'(grant_idx), 64'd1);
        tick();
        request(0, 32'h6100, 1'b0);
        rst = 1'b1;
        tick();
        check("rst_mid_scyc", 64'({s_cyc, s_stb, busy}), 64'd0);
        s_ack = 1'b1;
        #1;
        check("rst_mid_noresp", 64'({m_ack, m_err}), 64'd0);
        s_ack = 1'b0;
        rst   = 1'b0;
        tick();
        check("post_rst_busy", 64'(busy), 64'd1);
        check("post_rst_grant", 64'(grant_idx), 64'd0);
        s_ack      = 1'b1;
        s_dat_miso = 32'hF00D_0000;
        sb.push_back('{0, 32'hF00D_0000, 1'b0});
        tick();
        s_ack = 1'b0;
        drop(0);
        drop(1);
        repeat (3) tick();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
